// File: rtl/mmu_master.sv
// mmu_master: turns one client burst request into NONSEQ/SEQ bus transfers.
// Write beats are buffered in full before the burst starts; read beats are
// returned one cycle after each completing bus edge.
// Optional feature: define MMU_MASTER_WRAP_EN to execute wrapping bursts;
// without it, multi-beat wrapping requests are rejected with ERR.
module mmu_master #(
    parameter int WBUF_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_write_i,
    input  logic [2:0]  req_size_i,
    input  logic [2:0]  req_burst_i,
    input  logic        wdata_valid_i,
    output logic        wdata_ready_o,
    input  logic [31:0] wdata_i,
    output logic        rdata_valid_o,
    output logic [31:0] rdata_o,
    output logic        rdata_last_o,
    output logic        done_o,
    output logic        err_o,
    output logic        selx_o,
    output logic [31:0] addr_o,
    output logic [31:0] write_data_o,
    output logic        write_o,
    output logic [2:0]  size_o,
    output logic [2:0]  burst_o,
    output logic [2:0]  trans_o,
    input  logic [31:0] read_data_i,
    input  logic        readyout_i,
    input  logic        resp_i
);
    localparam int IW = $clog2(WBUF_DEPTH);
    localparam logic [2:0] TRANSFER_IDLE   = 3'd0;
    localparam logic [2:0] TRANSFER_NONSEQ = 3'd2;
    localparam logic [2:0] TRANSFER_SEQ    = 3'd3;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FILL, S_BURST, S_ERRW, S_FIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [4:0]  beat_q, beat_d;     // fill index in FILL, beat index in BURST
    logic        err_q, err_d;
    logic        write_q;
    logic [2:0]  size_q, burst_q;
    logic [31:0] wbuf_q [WBUF_DEPTH];
    logic [31:0] rdata_q;
    logic        rvalid_q, rlast_q;

    logic [4:0]  nbeats;
    logic        last_beat;
    logic [31:0] inc;
    logic [31:0] next_addr;
    logic [1:0]  align_mask;
    logic        reject;

    // Decode beat count, increment and the next beat address
    always_comb begin
        nbeats = 5'd1;
        case (burst_q[2:1])
            2'b00: nbeats = 5'd1;
            2'b01: nbeats = 5'd4;
            2'b10: nbeats = 5'd8;
            2'b11: nbeats = 5'd16;
            default: nbeats = 5'd1;
        endcase
    end

    assign last_beat  = (beat_q == 5'(nbeats - 5'd1));
    assign inc        = 32'd1 << size_q[1:0];
    assign align_mask = 2'((3'd1 << size_q[1:0]) - 3'd1);

`ifdef MMU_MASTER_WRAP_EN
    logic [6:0]  total_m1;
    logic [31:0] wmask;
    // Wrap boundary is the total burst size; only bits below it advance
    assign total_m1  = 7'((inc[6:0] * {2'b00, nbeats}) - 7'd1);
    assign wmask     = {25'd0, total_m1};
    assign next_addr = burst_q[0] ? ((addr_q & ~wmask) | ((addr_q + inc) & wmask))
                                  : (addr_q + inc);
    assign reject    = (size_q > 3'd2) || ((addr_q[1:0] & align_mask) != 2'b00);
`else
    assign next_addr = addr_q + inc;
    assign reject    = (size_q > 3'd2) || ((addr_q[1:0] & align_mask) != 2'b00)
                       || (burst_q[0] && (nbeats != 5'd1));
`endif

    // Next-state logic for the request/burst sequencer
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (req_valid_i) begin
                addr_d  = req_addr_i;
                beat_d  = 5'd0;
                err_d   = 1'b0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (reject) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = write_q ? S_FILL : S_BURST;
                end
            end
            S_FILL: if (wdata_valid_i) begin
                beat_d = 5'(beat_q + 5'd1);
                if (last_beat) begin
                    beat_d  = 5'd0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (readyout_i && !resp_i) begin
                    addr_d = next_addr;
                    beat_d = 5'(beat_q + 5'd1);
                    if (last_beat) state_d = S_FIN;
                end else if (resp_i && !readyout_i) begin
                    state_d = S_ERRW;
                end
            end
            S_ERRW: if (readyout_i) begin
                err_d   = 1'b1;
                state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state, address and beat counter registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Request capture, write-beat buffer and registered read return
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            write_q  <= 1'b0;
            size_q   <= '0;
            burst_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            for (int i = 0; i < WBUF_DEPTH; i++) wbuf_q[i] <= '0;
        end else begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (state_q == S_IDLE && req_valid_i) begin
                write_q <= req_write_i;
                size_q  <= req_size_i;
                burst_q <= req_burst_i;
            end
            if (state_q == S_FILL && wdata_valid_i)
                wbuf_q[IW'(beat_q)] <= wdata_i;
            if (state_q == S_BURST && readyout_i && !resp_i && !write_q) begin
                rdata_q  <= read_data_i;
                rvalid_q <= 1'b1;
                rlast_q  <= last_beat;
            end
        end
    end

    assign req_ready_o   = rstn_i && (state_q == S_IDLE);
    assign wdata_ready_o = (state_q == S_FILL);
    assign rdata_valid_o = rvalid_q;
    assign rdata_o       = rdata_q;
    assign rdata_last_o  = rlast_q;
    assign done_o        = (state_q == S_FIN);
    assign err_o         = (state_q == S_FIN) && err_q;
    assign selx_o        = (state_q == S_BURST);
    assign trans_o       = (state_q != S_BURST) ? TRANSFER_IDLE :
                           (beat_q == 5'd0) ? TRANSFER_NONSEQ : TRANSFER_SEQ;
    assign addr_o        = addr_q;
    assign write_data_o  = (state_q == S_BURST) ? wbuf_q[IW'(beat_q)] : '0;
    assign write_o       = write_q;
    assign size_o        = size_q;
    assign burst_o       = burst_q;
endmodule

// File: tb/tb_mmu_master.sv
// tb_mmu_master: scoreboard bench for mmu_master. Stimulus pushes expected
// bus transfers, read beats and completions; a negedge monitor pops and checks.
module tb_mmu_master;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_size = '0, req_burst = '0;
    logic        wdata_valid = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] read_data = '0;
    logic        readyout = 1'b1, resp = 1'b0;
    logic        req_ready, wdata_ready, rdata_valid, rdata_last, done, err;
    logic        selx, write;
    logic [31:0] rdata, addr, write_data;
    logic [2:0]  size, burst, trans;

    always #5 clk = ~clk;

    mmu_master #(.WBUF_DEPTH(16)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_size_i(req_size), .req_burst_i(req_burst),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
        .rdata_valid_o(rdata_valid), .rdata_o(rdata), .rdata_last_o(rdata_last),
        .done_o(done), .err_o(err),
        .selx_o(selx), .addr_o(addr), .write_data_o(write_data), .write_o(write),
        .size_o(size), .burst_o(burst), .trans_o(trans),
        .read_data_i(read_data), .readyout_i(readyout), .resp_i(resp)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } xfer_t;
    typedef struct {
        logic [31:0] data;
        logic        last;
    } rbeat_t;

    xfer_t  xq[$];
    rbeat_t rq[$];
    logic   dq[$];

    int n_tests = 0, n_fail = 0;
    int sbeat = 0, wd_cnt = 0, cur_beats = 0;
    int err_beat = 99, wait_beat = 99, wait_n = 0, wcnt = 0;
    bit rnd_wait = 1'b0, errph = 1'b0;

    function automatic logic [31:0] rdf(logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h1234;
    endfunction

    // Beat i address: linear, or modulo the total burst size inside its aligned window
    function automatic logic [31:0] exp_addr(longint a0, longint inc, longint n, bit wrap, longint i);
        longint total, base;
        total = inc * n;
        if (!wrap) return 32'(a0 + i * inc);
        base = a0 - (a0 % total);
        return 32'(base + ((a0 - base) + i * inc) % total);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus slave: data from address, directed wait/error injection, optional random waits
    always @(posedge clk) begin
        #1;
        readyout = 1'b1;
        resp     = 1'b0;
        if (!rstn) begin
            wcnt  = 0;
            errph = 1'b0;
        end else begin
            if (done) wcnt = 0;
            if (errph) begin
                resp  = 1'b1;
                errph = 1'b0;
            end else if (selx) begin
                if (sbeat == err_beat) begin
                    resp     = 1'b1;
                    readyout = 1'b0;
                    errph    = 1'b1;
                end else if (sbeat == wait_beat && wcnt < wait_n) begin
                    readyout = 1'b0;
                    wcnt++;
                end else if (rnd_wait && $urandom_range(3) == 0) begin
                    readyout = 1'b0;
                end
            end
        end
        read_data = rdf(addr);
    end

    // Monitor: compare whatever the DUT presents against the head of each queue
    always @(negedge clk) begin
        xfer_t  e;
        rbeat_t r;
        if (!rstn) begin
            xq.delete();
            rq.delete();
            dq.delete();
            sbeat = 0;
        end else begin
            if (selx) begin
                if (xq.size() == 0) begin
                    chk("unexpected_xfer", {29'd0, trans}, 32'hFFFF_FFFF);
                end else begin
                    e = xq[0];
                    chk("bus_addr", addr, e.addr);
                    chk("bus_trans", {29'd0, trans}, {29'd0, e.trans});
                    chk("bus_write", {31'd0, write}, {31'd0, e.wr});
                    chk("bus_size", {29'd0, size}, {29'd0, e.size});
                    chk("bus_burst", {29'd0, burst}, {29'd0, e.burst});
                    if (e.wr) begin
                        chk("bus_wdata", write_data, e.wdata);
                        chk("wbeats_before_selx", wd_cnt, cur_beats);
                    end
                    if (readyout || resp) void'(xq.pop_front());
                end
                if (readyout && !resp) sbeat++;
            end else begin
                chk("trans_idle", {29'd0, trans}, 32'd0);
            end
            if (rdata_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rdata", rdata, 32'hDEAD_BEEF ^ rdata ^ 32'h1);
                end else begin
                    r = rq.pop_front();
                    chk("rdata", rdata, r.data);
                    chk("rdata_last", {31'd0, rdata_last}, {31'd0, r.last});
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else chk("done_err", {31'd0, err}, {31'd0, dq.pop_front()});
                chk("leftover_xfers", xq.size(), 0);
                chk("leftover_rbeats", rq.size(), 0);
                sbeat = 0;
            end
        end
    end

    task automatic do_req(logic [31:0] a, bit wr, logic [2:0] sz, logic [2:0] bst,
                          bit seq_data, bit rst_mid);
        int n, inc, nx, nr, cyc;
        bit wrap, rej;
        logic [31:0] d [16];
        xfer_t  e;
        rbeat_t r;
        case (bst[2:1])
            2'b00: n = 1;
            2'b01: n = 4;
            2'b10: n = 8;
            default: n = 16;
        endcase
        inc  = 1 << sz;
        wrap = bst[0] && (n > 1);
        rej  = (sz > 3'd2) || ((a % inc) != 0);
`ifndef MMU_MASTER_WRAP_EN
        if (wrap) rej = 1'b1;
`endif
        for (int i = 0; i < 16; i++) d[i] = seq_data ? 32'(i + 1) : $urandom;
        cur_beats = n;
        wd_cnt    = 0;
        if (!rej) begin
            nx = (err_beat < n) ? err_beat + 1 : n;
            nr = (err_beat < n) ? err_beat : n;
            for (int i = 0; i < nx; i++) begin
                e.addr  = exp_addr(a, inc, n, wrap, i);
                e.trans = (i == 0) ? 3'd2 : 3'd3;
                e.wr    = wr;
                e.size  = sz;
                e.burst = bst;
                e.wdata = d[i];
                xq.push_back(e);
            end
            if (!wr) for (int i = 0; i < nr; i++) begin
                r.data = rdf(exp_addr(a, inc, n, wrap, i));
                r.last = (i == n - 1);
                rq.push_back(r);
            end
        end
        if (!rst_mid) dq.push_back(rej || (err_beat < n));

        @(posedge clk); #2;
        req_valid = 1'b1; req_addr = a; req_write = wr; req_size = sz; req_burst = bst;
        cyc = 0;
        @(negedge clk);
        while (!req_ready && cyc < 50) begin cyc++; @(negedge clk); end
        chk("accept_timeout", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #2;
        req_valid   = 1'b0;
        wdata_valid = wr;
        wdata       = d[0];
        @(negedge clk);
        chk("check_cycle_selx", {31'd0, selx}, 32'd0);
        chk("check_cycle_wrdy", {31'd0, wdata_ready}, 32'd0);
        if (rej) begin
            @(negedge clk);
            chk("reject_done_latency", {31'd0, done}, 32'd1);
            chk("reject_no_wdata", {31'd0, wdata_ready}, 32'd0);
            chk("reject_no_selx", {31'd0, selx}, 32'd0);
            wdata_valid = 1'b0;
        end else if (rst_mid) begin
            cyc = 0;
            while (!(selx && trans == 3'd3) && cyc < 50) begin cyc++; @(negedge clk); end
            chk("beat1_timeout", {31'd0, selx}, 32'd1);
            #1 rstn = 1'b0;
            #1;
            chk("rst_ctl", {16'd0, req_ready, wdata_ready, rdata_valid, rdata_last, done, err,
                            selx, write, size, burst, trans}, 32'd0);
            chk("rst_addr", addr, 32'd0);
            chk("rst_wdata", write_data, 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            repeat (2) @(posedge clk);
            #2 rstn = 1'b1;
        end else begin
            if (!wr && !rnd_wait) begin
                @(negedge clk);
                chk("read_nonseq_latency", {31'd0, selx}, 32'd1);
            end
            if (wr) begin
                for (int i = 0; i < n; i++) begin
                    wdata = d[i];
                    wdata_valid = 1'b1;
                    cyc = 0;
                    @(negedge clk);
                    while (!wdata_ready && cyc < 50) begin cyc++; @(negedge clk); end
                    if (!wdata_ready) begin
                        chk("wdata_timeout", 32'd0, 32'd1);
                        break;
                    end
                    @(posedge clk);
                    wd_cnt++;
                    #2 wdata_valid = 1'b0;
                    if ($urandom_range(3) == 0) begin @(posedge clk); #2; end
                end
                wdata_valid = 1'b0;
            end
            cyc = 0;
            while (!done && cyc < 400) begin @(negedge clk); cyc++; end
            chk("done_timeout", {31'd0, done}, 32'd1);
        end
        @(posedge clk); #2;
        err_beat = 99; wait_beat = 99; wait_n = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {16'd0, req_ready, wdata_ready, rdata_valid, rdata_last, done, err,
                          selx, write, size, burst, trans}, 32'd0);
        chk("reset_addr", addr, 32'd0);
        chk("reset_wdata", write_data, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(posedge clk); #2 rstn = 1'b1;
        #1 chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        rnd_wait = 1'b0;
        do_req(32'h10, 1'b0, 3'd2, 3'b000, 1'b0, 1'b0);   // single read
        do_req(32'h20, 1'b1, 3'd2, 3'b010, 1'b1, 1'b0);   // INCR4 write, data 1..4
        do_req(32'h38, 1'b0, 3'd2, 3'b011, 1'b0, 1'b0);   // WRAP4 read
        wait_beat = 1; wait_n = 2;
        do_req(32'h20, 1'b0, 3'd2, 3'b010, 1'b0, 1'b0);   // waits on beat 1
        err_beat = 2;
        do_req(32'h100, 1'b0, 3'd2, 3'b100, 1'b0, 1'b0);  // INCR8, error on beat 2
        do_req(32'h40, 1'b0, 3'd2, 3'b110, 1'b0, 1'b1);   // INCR16, reset on beat 1
        do_req(32'h0, 1'b0, 3'd2, 3'b000, 1'b0, 1'b0);    // post-reset read at 0
        do_req(32'h0, 1'b0, 3'd3, 3'b000, 1'b0, 1'b0);    // illegal size
        do_req(32'h42, 1'b1, 3'd2, 3'b010, 1'b0, 1'b0);   // misaligned write

        rnd_wait = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            sz = ($urandom_range(9) == 0) ? 3'd3 : 3'($urandom_range(2));
            a  = 32'($urandom_range(255)) * 4;
            if ($urandom_range(7) == 0) a = a + 32'($urandom_range(1, 3));
            if ($urandom_range(4) == 0) err_beat = $urandom_range(15);
            do_req(a, 1'($urandom_range(1)), sz, 3'($urandom_range(7)), 1'b0, 1'b0);
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mmu_master.md
# mmu_master

Bus master that turns one burst request from a client (cache/CPU side) into a sequence of transfers on the memory bus consumed by `mmu_unit`. It captures the request, buffers all write beats before issuing, generates NONSEQ/SEQ transfers with incrementing or wrapping addresses, honours wait states and the two-cycle error response, and returns read beats to the client.

## Interface
- `WBUF_DEPTH`, 16: write-beat buffer entries. Must be ≥16.
- `CLK`  in  1  clock; all state changes on rising edge.
- `RSTN`  in  1  reset, asynchronous, active-low.
- `REQ_VALID`  in  1  request present.
- `REQ_READY`  out  1  request accepted when both high at an edge.
- `REQ_ADDR`  in  32  start byte address.
- `REQ_WRITE`  in  1  1 = write burst.
- `REQ_SIZE`  in  3  log2 bytes per beat; 0..2 legal.
- `REQ_BURST`  in  3  [2:1] beats 00=1, 01=4, 10=8, 11=16; [0]=1 wrapping.
- `WDATA_VALID` / `WDATA_READY` / `WDATA`  in/out/in  1/1/32  write-beat handshake.
- `RDATA_VALID`  out  1  read beat valid, one cycle, no backpressure.
- `RDATA`  out  32  read beat data.
- `RDATA_LAST`  out  1  with final read beat.
- `DONE`  out  1  one-cycle pulse, request finished.
- `ERR`  out  1  qualifies `DONE`: rejected or bus error.
- `SELX`, `ADDR`[32], `WRITE_DATA`[32], `WRITE`, `SIZE`[3], `BURST`[3], `TRANS`[3]  out  bus request to `mmu_unit`.
- `READ_DATA`[32], `READYOUT`, `RESP`  in  bus response.

## Operation
- States: IDLE, CHECK, FILL, BURST, ERRW, FIN.
- IDLE: `REQ_READY`=1; on accept capture addr/write/size/burst, go CHECK.
- CHECK (1 cycle): reject if `SIZE`>2, address not aligned to 1<<SIZE, or wrapping while disabled (see Configuration) → FIN with `ERR`. No write data consumed on reject. Else write → FILL, read → BURST.
- FILL: `WDATA_READY`=1 until beat count captured into buffer index 0..N-1; then BURST.
- BURST: `SELX`=1; `TRANS`=TRANSFER_NONSEQ (3'd2) for beat 0, TRANSFER_SEQ (3'd3) after; `WRITE_DATA`=buffer[beat]. `SIZE`/`BURST`/`WRITE` held at captured values for whole burst.
- Beat completes at edge with `READYOUT`=1, `RESP`=0: sample `READ_DATA` (reads), advance address and 5-bit beat counter. After last beat → FIN.
- Increment inc = 1<<SIZE; total = inc × beats (≤64, 7 bits). Incrementing: addr+inc. Wrapping: (addr & ~(total-1)) | ((addr+inc) & (total-1)).
- Edge with `RESP`=1, `READYOUT`=0 (error cycle 1) → ERRW: `TRANS`=TRANSFER_IDLE (3'd0), `SELX`=0. Edge in ERRW with `READYOUT`=1 → FIN with `ERR`. Remaining beats abandoned.
- FIN: `DONE`=1 one cycle, `ERR` as recorded; → IDLE.

## Timing
- Reset values: `REQ_READY`=0 during reset then 1, `WDATA_READY`=0, `RDATA_VALID`=0, `RDATA`=0, `RDATA_LAST`=0, `DONE`=0, `ERR`=0, `SELX`=0, `ADDR`=0, `WRITE_DATA`=0, `WRITE`=0, `SIZE`=0, `BURST`=0, `TRANS`=3'd0. Buffer and counters cleared.
- Reset assertion mid-burst: outputs to reset values immediately, no `DONE`.
- Read latency: accept edge → CHECK → first NONSEQ 2 cycles after accept.
- `RDATA_VALID` registered: asserted the cycle after the completing edge; `RDATA_LAST` on beat N-1.
- Wait states: while `READYOUT`=0 and `RESP`=0, bus outputs held stable.
- Back-to-back beats with zero wait: one beat per cycle.
- Requests during non-IDLE ignored (`REQ_READY`=0).

## Configuration
- `MMU_MASTER_WRAP_EN` defined: wrapping bursts (`REQ_BURST[0]`=1, beats>1) executed with wrap addressing.
- Undefined: such requests rejected in CHECK (`DONE`+`ERR`, `SELX` never asserted); wrap logic not compiled.

## Test plan
- Read 0x10, SIZE=2, BURST=000, zero wait → one NONSEQ at 0x10; one `RDATA_VALID` with `RDATA_LAST`; `DONE`, `ERR`=0.
- Write 0x20, SIZE=2, BURST=010 (INCR4), data 1..4 → four `WDATA` accepted before `SELX`; NONSEQ 0x20, SEQ 0x24, 0x28, 0x2C with `WRITE_DATA` 1..4.
- Read 0x38, SIZE=2, BURST=011 with macro → addresses 0x38, 0x3C, 0x30, 0x34; without macro → `DONE`+`ERR` 2 cycles after accept, `SELX` stays 0.
- INCR4 read, `READYOUT`=0 two cycles on beat 1 → `ADDR`=0x24 and `TRANS`=SEQ held; completes with 4 `RDATA_VALID`.
- INCR8 read, beat 2 gets `RESP`=1/`READYOUT`=0 then `RESP`=1/`READYOUT`=1 → `TRANS`=IDLE in second cycle; 2 `RDATA_VALID`; `DONE` with `ERR`=1.
- `RSTN` low during beat 1 of INCR16 → all outputs reset same cycle; post-reset request at 0x0 issues NONSEQ at 0x0; SIZE=3 request → rejected with `ERR`.
